div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Clock and reset SHALL be a single clock and a synchronous active-high reset; reset is sampled only on the rising clock edge.
REQ-002 Ports:
  clk  input  1  sole clock, rising edge
  rst  input  1  synchronous reset, active high
  StartE  input  1  execute-stage div/divu present; request to begin
  SignedE  input  1  1 = div (two's complement), 0 = divu
  AnnulE  input  1  execute-stage flush; abandon any divide in progress
  SrcAE  input  32  dividend (forwarded rs)
  SrcBE  input  32  divisor (forwarded rt)
  DivStallE  output  1  stall request to hazard unit (holds F/D/E, bubbles M)
  ReadyE  output  1  one-cycle strobe; results valid, HI/LO write enable
  HIResultE  output  32  remainder
  LOResultE  output  32  quotient

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-004 In IDLE, when StartE=1 and AnnulE=0, the unit SHALL capture operands at that edge (cycle T) and enter RUN.
REQ-005 Capture SHALL store |SrcAE| and |SrcBE| when SignedE=1, raw values when SignedE=0, plus quotient-sign (signs differ) and remainder-sign (dividend sign) flags.
REQ-006 RUN SHALL perform one restoring radix-2 step per cycle for exactly 32 cycles, using a 5-bit iteration counter and a 33-bit partial-remainder subtract.
REQ-007 After the 32nd step, the FSM SHALL enter DONE. DONE SHALL last exactly one cycle (T+33), then return to IDLE unconditionally.
REQ-008 ReadyE SHALL be 1 only in DONE.
REQ-009 HIResultE/LOResultE SHALL be valid during DONE and SHALL hold until the next accepted start.
REQ-010 Sign fix-up SHALL be applied before DONE: quotient negated if the signs differ; remainder negated if the dividend is negative.
REQ-011 DivStallE SHALL be combinational: (IDLE & StartE & ~AnnulE) | RUN. It is therefore high in cycles T..T+32 and low in DONE, so the instruction leaves E with ReadyE=1.
REQ-012 Divisor zero SHALL NOT shortcut. The 32 steps run as normal, giving quotient 0xFFFFFFFF and remainder = dividend (unsigned path, before fix-up).
REQ-013 Signed 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0x00000000 with no exception.
REQ-014 StartE in RUN or DONE SHALL be ignored; operands are not re-captured.
REQ-015 AnnulE=1 in RUN SHALL return the FSM to IDLE at the next edge, with no ReadyE and result registers unchanged.
REQ-016 AnnulE together with StartE in IDLE SHALL NOT start a divide.

Reset
REQ-017 rst=1 SHALL force: state IDLE, counter 0, DivStallE=0, ReadyE=0, HIResultE=0, LOResultE=0, internal operand/remainder registers 0.
REQ-018 Reset asserted mid-RUN SHALL abort the divide with no ReadyE pulse.
REQ-019 If rst and StartE are both 1, reset SHALL win.

Structure
REQ-020 A shared package div_defs SHALL hold the state encoding (IDLE/RUN/DONE) and the constants DIV_WIDTH=32 and DIV_ITERS=32.
REQ-021 One sub-module div_step SHALL implement a single combinational restoring step: inputs are partial remainder, quotient shift register and divisor; outputs are the next remainder and next quotient. The FSM and registers live in div_unit.

Verification
REQ-022 Unsigned: StartE=1, SignedE=0, SrcAE=100, SrcBE=7 at T -> DivStallE high T..T+32; at T+33 ReadyE=1, LO=14, HI=2.
REQ-023 Signed: SrcAE=-7 (0xFFFFFFF9), SrcBE=2 -> at T+33 LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-024 Divide by zero, unsigned: SrcAE=0x12345678, SrcBE=0 -> at T+33 LO=0xFFFFFFFF, HI=0x12345678, ReadyE=1.
REQ-025 Overflow case: signed 0x80000000 / 0xFFFFFFFF -> at T+33 LO=0x80000000, HI=0.
REQ-026 AnnulE=1 at T+10 -> IDLE at T+11, DivStallE=0 from T+11, no ReadyE through T+40; a new start at T+12 completes at T+45.
REQ-027 rst=1 at T+20 -> all outputs 0 at T+21 and no ReadyE; StartE held high together with rst causes no capture.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: FSM encoding and datapath sizing.
package div_defs;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = 32;
  localparam int CNT_WIDTH = $clog2(DIV_ITERS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/div_unit_step.sv
// One combinational restoring radix-2 step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only if it did not borrow.
module div_step
  import div_defs::*;
(
  input  logic [DIV_WIDTH-1:0] rem,
  input  logic [DIV_WIDTH-1:0] quo,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic [DIV_WIDTH-1:0] rem_next,
  output logic [DIV_WIDTH-1:0] quo_next
);

  logic [DIV_WIDTH:0] shifted;
  logic [DIV_WIDTH:0] diff;

  // The partial remainder always stays below 2*divisor, so 33 bits hold the trial result.
  always_comb begin
    shifted = {rem, quo[DIV_WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    if (diff[DIV_WIDTH]) begin
      rem_next = shifted[DIV_WIDTH-1:0];
      quo_next = {quo[DIV_WIDTH-2:0], 1'b0};
    end else begin
      rem_next = diff[DIV_WIDTH-1:0];
      quo_next = {quo[DIV_WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle div/divu unit for the execute stage: 32 restoring steps on operand
// magnitudes, then sign fix-up into HI (remainder) / LO (quotient).
module div_unit
  import div_defs::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 StartE,
  input  logic                 SignedE,
  input  logic                 AnnulE,
  input  logic [DIV_WIDTH-1:0] SrcAE,
  input  logic [DIV_WIDTH-1:0] SrcBE,
  output logic                 DivStallE,
  output logic                 ReadyE,
  output logic [DIV_WIDTH-1:0] HIResultE,
  output logic [DIV_WIDTH-1:0] LOResultE
);

  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] count;
  logic [DIV_WIDTH-1:0] rem;
  logic [DIV_WIDTH-1:0] quo;
  logic [DIV_WIDTH-1:0] divisor;
  logic                 q_neg;
  logic                 r_neg;
  logic [DIV_WIDTH-1:0] hi_q;
  logic [DIV_WIDTH-1:0] lo_q;
  logic [DIV_WIDTH-1:0] rem_next;
  logic [DIV_WIDTH-1:0] quo_next;
  logic                 accept;

  div_step u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (divisor),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  assign accept = (state == IDLE) && StartE && !AnnulE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // The quotient register starts as the dividend magnitude and shifts out one bit per step.
            quo     <= (SignedE && SrcAE[DIV_WIDTH-1]) ? -SrcAE : SrcAE;
            divisor <= (SignedE && SrcBE[DIV_WIDTH-1]) ? -SrcBE : SrcBE;
            q_neg   <= SignedE && (SrcAE[DIV_WIDTH-1] != SrcBE[DIV_WIDTH-1]);
            r_neg   <= SignedE && SrcAE[DIV_WIDTH-1];
            rem     <= '0;
            count   <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (AnnulE) begin
            state <= IDLE;
          end else begin
            rem   <= rem_next;
            quo   <= quo_next;
            count <= count + 1'b1;
            if (count == CNT_WIDTH'(DIV_ITERS - 1)) begin
              lo_q  <= q_neg ? -quo_next : quo_next;
              hi_q  <= r_neg ? -rem_next : rem_next;
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stall is gated by reset so the hazard unit sees a quiet divider while reset is held.
  assign DivStallE = !rst && (accept || (state == RUN));
  assign ReadyE    = (state == DONE);
  assign HIResultE = hi_q;
  assign LOResultE = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases, randomized operands
// against an arithmetic reference model, annul/reset/ignored-start scenarios.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        StartE;
  logic        SignedE;
  logic        AnnulE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        DivStallE;
  logic        ReadyE;
  logic [31:0] HIResultE;
  logic [31:0] LOResultE;

  int passed = 0;
  int total  = 0;
  logic [31:0] last_hi;
  logic [31:0] last_lo;

  div_unit dut (
    .clk       (clk),
    .rst       (rst),
    .StartE    (StartE),
    .SignedE   (SignedE),
    .AnnulE    (AnnulE),
    .SrcAE     (SrcAE),
    .SrcBE     (SrcBE),
    .DivStallE (DivStallE),
    .ReadyE    (ReadyE),
    .HIResultE (HIResultE),
    .LOResultE (LOResultE)
  );

  always #5 clk = ~clk;

  // Reference: divide magnitudes with ordinary arithmetic, x/0 gives all-ones and remainder x.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r);
    logic        neg_a, neg_b;
    logic [31:0] ua, ub;
    neg_a = s && a[31];
    neg_b = s && b[31];
    ua = neg_a ? -a : a;
    ub = neg_b ? -b : b;
    if (ub == 0) begin
      q = 32'hFFFF_FFFF;
      r = ua;
    end else begin
      q = ua / ub;
      r = ua % ub;
    end
    if (neg_a != neg_b) q = -q;
    if (neg_a) r = -r;
  endfunction

  // Launches one divide from IDLE and observes it; caller is just past a rising edge.
  task automatic do_divide(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output bit stall_ok, output int ready_at,
                           output logic [31:0] hi, output logic [31:0] lo);
    stall_ok = 1'b1;
    ready_at = -1;
    hi = '0;
    lo = '0;
    StartE = 1'b1; SignedE = s; SrcAE = a; SrcBE = b;
    @(negedge clk);
    if (DivStallE !== 1'b1) stall_ok = 1'b0;
    @(posedge clk); #1;
    StartE = 1'b0; SrcAE = $urandom; SrcBE = $urandom; SignedE = ~s;
    for (int i = 1; i <= 40 && ready_at < 0; i++) begin
      @(negedge clk);
      if (ReadyE === 1'b1) begin
        ready_at = i;
        hi = HIResultE;
        lo = LOResultE;
        if (DivStallE !== 1'b0) stall_ok = 1'b0;
      end else if (DivStallE !== 1'b1) begin
        stall_ok = 1'b0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; StartE = 1'b1; SignedE = 1'b0; AnnulE = 1'b0;
    SrcAE = 32'd100; SrcBE = 32'd7;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({DivStallE, ReadyE, HIResultE, LOResultE} !== 66'd0)
      $display("[TB] FAIL reset_outputs: got stall=%b ready=%b hi=%h lo=%h, expected all 0",
               DivStallE, ReadyE, HIResultE, LOResultE);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0; StartE = 1'b0;
    @(negedge clk);
    total++;
    if (DivStallE !== 1'b0)
      $display("[TB] FAIL reset_no_capture: stall=%b expected 0", DivStallE);
    else passed++;
    @(posedge clk); #1;
    last_hi = '0;
    last_lo = '0;
  endtask

  task automatic test_directed;
    logic [31:0] ta [4] = '{32'd100, 32'hFFFF_FFF9, 32'h1234_5678, 32'h8000_0000};
    logic [31:0] tb [4] = '{32'd7,   32'd2,         32'd0,         32'hFFFF_FFFF};
    logic        ts [4] = '{1'b0,    1'b1,          1'b0,          1'b1};
    logic [31:0] el [4] = '{32'd14,  32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] eh [4] = '{32'd2,   32'hFFFF_FFFF, 32'h1234_5678, 32'h0};
    bit          sok;
    int          rat;
    logic [31:0] hi, lo;
    for (int k = 0; k < 4; k++) begin
      do_divide(ta[k], tb[k], ts[k], sok, rat, hi, lo);
      total++;
      if (rat != 33 || !sok)
        $display("[TB] FAIL directed%0d_timing: ready at T+%0d stall_ok=%0d, expected T+33 stall_ok=1", k, rat, sok);
      else passed++;
      total++;
      if (lo !== el[k] || hi !== eh[k])
        $display("[TB] FAIL directed%0d_result: got lo=%h hi=%h, expected lo=%h hi=%h", k, lo, hi, el[k], eh[k]);
      else passed++;
      @(negedge clk);
      total++;
      if (ReadyE !== 1'b0 || LOResultE !== el[k] || HIResultE !== eh[k])
        $display("[TB] FAIL directed%0d_hold: got ready=%b lo=%h hi=%h, expected ready=0 lo=%h hi=%h",
                 k, ReadyE, LOResultE, HIResultE, el[k], eh[k]);
      else passed++;
      @(posedge clk); #1;
      last_hi = eh[k];
      last_lo = el[k];
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b, eq, er, hi, lo;
    logic        s;
    bit          sok;
    int          rat;
    for (int n = 0; n < 24; n++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF;
        default: b = $urandom >> $urandom_range(0, 28);
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 1) == 1) b = -b;
      s = 1'($urandom_range(0, 1));
      model(a, b, s, eq, er);
      do_divide(a, b, s, sok, rat, hi, lo);
      total++;
      if (rat != 33 || !sok || lo !== eq || hi !== er)
        $display("[TB] FAIL random%0d a=%h b=%h s=%b: got lo=%h hi=%h ready T+%0d stall_ok=%0d, expected lo=%h hi=%h T+33",
                 n, a, b, s, lo, hi, rat, sok, eq, er);
      else passed++;
      last_hi = er;
      last_lo = eq;
    end
  endtask

  task automatic test_start_ignored;
    logic [31:0] eq, er;
    int          rat;
    model(32'd1000, 32'd33, 1'b0, eq, er);
    StartE = 1'b1; SignedE = 1'b0; SrcAE = 32'd1000; SrcBE = 32'd33;
    @(posedge clk); #1;
    SrcAE = 32'd5; SrcBE = 32'd2; SignedE = 1'b1;
    rat = -1;
    for (int i = 1; i <= 40 && rat < 0; i++) begin
      @(negedge clk);
      if (ReadyE === 1'b1) rat = i;
    end
    total++;
    if (rat != 33 || LOResultE !== eq || HIResultE !== er)
      $display("[TB] FAIL start_ignored: got lo=%h hi=%h ready T+%0d, expected lo=%h hi=%h T+33",
               LOResultE, HIResultE, rat, eq, er);
    else passed++;
    @(posedge clk); #1;
    StartE = 1'b0;
    @(negedge clk);
    total++;
    if (DivStallE !== 1'b0 || ReadyE !== 1'b0)
      $display("[TB] FAIL start_in_done: got stall=%b ready=%b, expected 0 0", DivStallE, ReadyE);
    else passed++;
    @(posedge clk); #1;
    last_hi = er;
    last_lo = eq;
  endtask

  task automatic test_annul;
    logic [31:0] eq, er, hi, lo;
    bit          sok;
    int          rat;
    StartE = 1'b1; SignedE = 1'b0; SrcAE = 32'hDEAD_BEEF; SrcBE = 32'd3;
    @(posedge clk); #1;
    StartE = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    AnnulE = 1'b1;
    @(posedge clk); #1;
    AnnulE = 1'b0;
    @(negedge clk);
    total++;
    if (DivStallE !== 1'b0 || ReadyE !== 1'b0 || HIResultE !== last_hi || LOResultE !== last_lo)
      $display("[TB] FAIL annul_idle: got stall=%b ready=%b hi=%h lo=%h, expected 0 0 hi=%h lo=%h",
               DivStallE, ReadyE, HIResultE, LOResultE, last_hi, last_lo);
    else passed++;
    @(posedge clk); #1;
    model(32'd77, 32'd5, 1'b0, eq, er);
    do_divide(32'd77, 32'd5, 1'b0, sok, rat, hi, lo);
    total++;
    if (rat != 33 || !sok || lo !== eq || hi !== er)
      $display("[TB] FAIL annul_restart: got lo=%h hi=%h ready T+%0d, expected lo=%h hi=%h T+33",
               lo, hi, rat, eq, er);
    else passed++;
    last_hi = er;
    last_lo = eq;
  endtask

  task automatic test_annul_start_idle;
    int seen;
    StartE = 1'b1; AnnulE = 1'b1; SignedE = 1'b0; SrcAE = 32'd50; SrcBE = 32'd5;
    @(negedge clk);
    total++;
    if (DivStallE !== 1'b0)
      $display("[TB] FAIL annul_start_stall: got %b expected 0", DivStallE);
    else passed++;
    @(posedge clk); #1;
    StartE = 1'b0; AnnulE = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ReadyE === 1'b1 || DivStallE === 1'b1) seen++;
    end
    total++;
    if (seen != 0 || LOResultE !== last_lo)
      $display("[TB] FAIL annul_start_nostart: busy cycles=%0d lo=%h, expected 0 lo=%h", seen, LOResultE, last_lo);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run;
    int seen;
    StartE = 1'b1; SignedE = 1'b1; SrcAE = 32'h7654_3210; SrcBE = 32'd9;
    @(posedge clk); #1;
    StartE = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    rst = 1'b1; StartE = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; StartE = 1'b0;
    @(negedge clk);
    total++;
    if ({DivStallE, ReadyE, HIResultE, LOResultE} !== 66'd0)
      $display("[TB] FAIL reset_mid_run: got stall=%b ready=%b hi=%h lo=%h, expected all 0",
               DivStallE, ReadyE, HIResultE, LOResultE);
    else passed++;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ReadyE === 1'b1 || DivStallE === 1'b1) seen++;
    end
    total++;
    if (seen != 0)
      $display("[TB] FAIL reset_no_ready: busy cycles=%0d expected 0", seen);
    else passed++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_annul();
    test_annul_start_idle();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
